// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scan controller.
//   key_state_e    - debounce FSM state (also exported as a debug port)
//   frame_class_e  - classification of one full-matrix frame
//   frame_info_t   - class plus key code of a frame
//   classify_frame - maps a 16-bit frame snapshot to frame_info_t
package keypad_pkg;

  localparam int DEFAULT_CLK_FREQ = 25_000_000;

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } key_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_class_e;

  typedef struct packed {
    frame_class_e cls;
    logic [3:0]   code;
  } frame_info_t;

  // Snapshot bit position is col*4+row, while the key code is row*4+col,
  // so the two 2-bit halves of the position are swapped to form the code.
  function automatic frame_info_t classify_frame(input logic [15:0] snap);
    frame_info_t r;
    int unsigned ones;
    logic [3:0]  pos;
    ones = 0;
    pos  = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones = ones + 1;
        pos  = 4'(i);
      end
    end
    if (ones == 0)      r.cls = FR_NONE;
    else if (ones == 1) r.cls = FR_SINGLE;
    else                r.cls = FR_MULTI;
    r.code = {pos[1:0], pos[3:2]};
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: key-event stream from the scanner to its consumer.
//   key_valid - event available; key_code stable while high
//   key_code  - row*4 + col of the pressed key
//   key_ready - consumer accepts the event
// Handshake: an event transfers on every rising clk edge where key_valid and
// key_ready are both 1. The master never drops key_valid or changes key_code
// before the transfer; the consumer may drive key_ready freely.
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-stability counter and key FSM.
//   clk, rst_n  - clock, asynchronous active-low reset
//   eof_i       - one-cycle strobe at end of each frame
//   cls_i       - class of the frame ending this cycle
//   code_i      - key code of that frame (meaningful for FR_SINGLE)
//   ev_o        - press event strobe (same cycle as eof_i)
//   ev_code_o   - code belonging to ev_o
//   held_o      - a debounced key is down
//   state_o     - current FSM state for debug
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         eof_i,
  input  frame_class_e cls_i,
  input  logic [3:0]   code_i,
  output logic         ev_o,
  output logic [3:0]   ev_code_o,
  output logic         held_o,
  output key_state_e   state_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  // The count is compared before incrementing, so it stops one short of
  // DEBOUNCE_SCANS and can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    ev_o      = 1'b0;
    // With a single-scan debounce the event comes straight from RELEASED.
    ev_code_o = (state_q == ST_RELEASED) ? code_i : cand_q;
    if (eof_i) begin
      unique case (state_q)
        ST_RELEASED: begin
          if (cls_i == FR_SINGLE) begin
            cand_d = code_i;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              ev_o    = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_PRESS_DB: begin
          if (cls_i == FR_SINGLE && code_i == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              ev_o    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (cls_i == FR_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_RELEASED;
              cnt_d   = '0;
            end else begin
              state_d = ST_RELEASE_DB;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_RELEASE_DB: begin
          if (cls_i == FR_NONE) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_RELEASED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign held_o  = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);
  assign state_o = state_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and event output.
//   clk, rst_n  - clock, asynchronous active-low reset
//   row_n       - keypad rows, active-low (pulled up)
//   col_n       - column drive, exactly one bit low
//   evt         - key-event stream (master side)
//   key_held    - a debounced key is down
//   overflow    - one-cycle pulse when a press event is dropped
//   dbg_state_o - debounce FSM state
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                row_n,
  output logic [3:0]                col_n,
  keypad_scan_ctrl_if.master        evt,
  output logic                      key_held,
  output logic                      overflow,
  output key_state_e                dbg_state_o
);

  localparam int COL_CYCLES = CLK_FREQ / (SCAN_HZ * 4);
  localparam int SLOT_W     = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COL_CYCLES - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        col_n_q, col_n_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [15:0]       snap_q, snap_d;
  logic              valid_q, valid_d;
  logic [3:0]        code_q, code_d;
  logic              ovf_q, ovf_d;

  logic              last_slot, eof;
  logic [15:0]       frame_now;
  frame_info_t       info;
  logic              ev;
  logic [3:0]        ev_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      col_q   <= '0;
      col_n_q <= 4'b1110;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      snap_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      col_q   <= col_d;
      col_n_q <= col_n_d;
      sync1_q <= row_n;
      sync2_q <= sync1_q;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    last_slot = (slot_q == SLOT_LAST);
    eof       = last_slot && (col_q == 2'd3);
    slot_d    = last_slot ? '0 : slot_q + SLOT_W'(1);
    col_d     = last_slot ? col_q + 2'd1 : col_q;
    col_n_d   = ~(4'b0001 << col_d);
    snap_d    = snap_q;
    if (last_slot) snap_d[{col_q, 2'b00} +: 4] = ~sync2_q;
    // The column-3 rows are sampled on the same edge the frame is judged,
    // so splice them in directly rather than waiting for snap_q.
    frame_now          = snap_q;
    frame_now[12 +: 4] = ~sync2_q;
    info = classify_frame(frame_now);
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .eof_i    (eof),
    .cls_i    (info.cls),
    .code_i   (info.code),
    .ev_o     (ev),
    .ev_code_o(ev_code),
    .held_o   (key_held),
    .state_o  (dbg_state_o)
  );

  // One-deep event buffer: a new event replaces a consumed one in the same
  // cycle; an event arriving while the old one is still unaccepted is lost.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    if (valid_q && evt.key_ready) valid_d = 1'b0;
    if (ev) begin
      if (valid_q && !evt.key_ready) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = ev_code;
      end
    end
  end

  assign col_n         = col_n_q;
  assign evt.key_valid = valid_q;
  assign evt.key_code  = code_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad scanner bench with a physical keypad model
// (pressed-key set shorted onto rows by the driven column) and a frame-level
// behavioural reference for debounce, events and the handshake.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int CLK_FREQ = 4000;
  localparam int SCAN_HZ  = 250;
  localparam int DB       = 2;
  localparam int FRAME    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_held;
  logic       overflow;
  key_state_e dbg_state;
  logic [15:0] keys = '0;  // bit row*4+col set = key pressed

  keypad_scan_ctrl_if evt();

  keypad_scan_ctrl #(
    .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .evt(evt),
    .key_held(key_held), .overflow(overflow), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
  end

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int ovf_count = 0;

  // Reference model state
  int         cyc = 0;
  bit         m_held = 0;
  int         run_len = 0;
  int         run_code = 0;
  int         none_run = 0;
  bit         exp_valid = 0;
  logic [3:0] exp_code = '0;
  bit         exp_ovf = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_held = 0; run_len = 0; run_code = 0; none_run = 0;
    exp_valid = 0; exp_code = '0; exp_ovf = 0;
  endtask

  // Judge one whole frame of the current key set.
  task automatic model_frame(output bit ev, output logic [3:0] code);
    int n;
    int c;
    n = 0; c = 0; ev = 0; code = '0;
    for (int i = 0; i < 16; i++) if (keys[i]) begin n++; c = i; end
    if (!m_held) begin
      if (run_len > 0) begin
        // The frame that breaks a run is spent, it does not start a new run.
        if (n == 1 && c == run_code) run_len++;
        else run_len = 0;
      end else if (n == 1) begin
        run_len = 1; run_code = c;
      end
      if (run_len == DB) begin
        ev = 1; code = 4'(run_code); m_held = 1; run_len = 0; none_run = 0;
      end
    end else begin
      if (n == 0) none_run++;
      else none_run = 0;
      if (none_run == DB) begin m_held = 0; none_run = 0; end
    end
  endtask

  task automatic tick();
    bit         rdy;
    bit         ev;
    logic [3:0] c;
    logic [3:0] exp_col;
    key_state_e exp_st;
    rdy = evt.key_ready;
    @(posedge clk);
    cyc++;
    ev = 0; c = '0;
    if (cyc % FRAME == 0) model_frame(ev, c);
    exp_ovf = 0;
    if (ev && exp_valid && !rdy) begin
      exp_ovf = 1;
    end else begin
      if (exp_valid && rdy) exp_valid = 0;
      if (ev) begin exp_valid = 1; exp_code = c; end
    end
    @(negedge clk);
    exp_col = 4'b0001 << ((cyc / 4) % 4);
    exp_col = ~exp_col;
    if (!m_held) exp_st = (run_len > 0) ? ST_PRESS_DB : ST_RELEASED;
    else         exp_st = (none_run > 0) ? ST_RELEASE_DB : ST_HELD;
    check("col_n", 16'(col_n), 16'(exp_col));
    check("key_valid", 16'(evt.key_valid), 16'(exp_valid));
    check("key_code", 16'(evt.key_code), 16'(exp_code));
    check("overflow", 16'(overflow), 16'(exp_ovf));
    check("key_held", 16'(key_held), 16'(m_held));
    check("fsm_state", 16'(dbg_state), 16'(exp_st));
    if (evt.key_valid) valid_cycles++;
    if (overflow) ovf_count++;
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n);
    keys = mask;
    repeat (n * FRAME) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"}, 16'(col_n), 16'(4'b1110));
    check({tag, "_key_valid"}, 16'(evt.key_valid), 16'(0));
    check({tag, "_key_code"}, 16'(evt.key_code), 16'(0));
    check({tag, "_key_held"}, 16'(key_held), 16'(0));
    check({tag, "_overflow"}, 16'(overflow), 16'(0));
    check({tag, "_fsm_state"}, 16'(dbg_state), 16'(ST_RELEASED));
  endtask

  initial begin
    int v0;
    int rsel;
    int code;
    int other;
    int nfr;
    logic [15:0] mask;

    // Reset
    evt.key_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // Idle scanning: column walk every 4 cycles
    run_frames(16'h0000, 2);

    // Key 9 (row 2, col 1) for 3 frames, consumer always ready
    v0 = valid_cycles;
    run_frames(16'h0001 << 9, 3);
    check("k9_valid_pulses", 16'(valid_cycles - v0), 16'(1));
    check("k9_held", 16'(key_held), 16'(1));
    run_frames(16'h0000, 2);

    // One-frame glitch on key 0
    v0 = valid_cycles;
    run_frames(16'h0001, 1);
    run_frames(16'h0000, 2);
    check("glitch_no_event", 16'(valid_cycles - v0), 16'(0));
    check("glitch_state", 16'(dbg_state), 16'(ST_RELEASED));

    // Overflow: code 5 pending, code 6 arrives
    evt.key_ready = 1'b0;
    run_frames(16'h0001 << 5, 2);
    run_frames(16'h0000, 2);
    v0 = ovf_count;
    run_frames(16'h0001 << 6, 2);
    check("ovf_pulses", 16'(ovf_count - v0), 16'(1));
    check("ovf_keep_valid", 16'(evt.key_valid), 16'(1));
    check("ovf_keep_code", 16'(evt.key_code), 16'(5));
    evt.key_ready = 1'b1;
    run_frames(16'h0000, 2);
    check("ovf_drained", 16'(evt.key_valid), 16'(0));

    // Two keys together, then 3 alone
    v0 = valid_cycles;
    run_frames((16'h0001 << 3) | (16'h0001 << 12), 2);
    check("multi_no_event", 16'(valid_cycles - v0), 16'(0));
    run_frames(16'h0001 << 3, 2);
    check("multi_then_3_event", 16'(valid_cycles - v0), 16'(1));
    check("multi_then_3_code", 16'(evt.key_code), 16'(3));
    run_frames(16'h0000, 2);

    // Randomized key sequences with a random consumer
    code = $urandom_range(0, 15);
    for (int seg = 0; seg < 40; seg++) begin
      rsel = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) code = $urandom_range(0, 15);
      if (rsel < 4) mask = '0;
      else if (rsel < 9) mask = 16'h0001 << code;
      else begin
        other = (code + $urandom_range(1, 15)) % 16;
        mask = (16'h0001 << code) | (16'h0001 << other);
      end
      keys = mask;
      nfr = $urandom_range(1, 3);
      repeat (nfr * FRAME) begin
        evt.key_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    evt.key_ready = 1'b1;
    run_frames(16'h0000, 2);

    // Reset mid-frame while in PRESS_DB with an event still pending
    evt.key_ready = 1'b0;
    run_frames(16'h0001 << 7, 2);
    run_frames(16'h0000, 2);
    run_frames(16'h0001 << 7, 1);
    repeat (5) tick();
    check("pre_reset_state", 16'(dbg_state), 16'(ST_PRESS_DB));
    check("pre_reset_pending", 16'(evt.key_valid), 16'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    model_reset();
    evt.key_ready = 1'b1;
    check("restart_col", 16'(col_n), 16'(4'b1110));
    run_frames(16'h0001 << 7, 2);
    run_frames(16'h0000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
